// File: rtl/fft_fix_pkg.sv
// Shared fixed-point definitions for the FFT datapath and its calibration divider.
// Widths, saturation limits, divider FSM states and the quotient clamp helper.
package fft_fix_pkg;

    localparam int unsigned DW   = 17;
    localparam int unsigned CW   = 8;
    localparam int unsigned FRAC = 7;
    localparam int unsigned QW   = DW + FRAC;
    localparam int unsigned RW   = CW + 1;
    localparam int unsigned CNTW = $clog2(QW);

    localparam logic [DW-1:0] POS_MAX = 17'h0FFFF;
    localparam logic [DW-1:0] NEG_MIN = 17'h10000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {sat, q}: applies the sign to a truncated magnitude and clamps to DW bits.
    function automatic logic [DW:0] sat_quot(input logic sign, input logic [QW-1:0] mag);
        logic [DW:0]   res;
        logic [DW-1:0] m;
        m = mag[DW-1:0];
        if (!sign) begin
            if (mag > {{(QW-DW){1'b0}}, POS_MAX}) res = {1'b1, POS_MAX};
            else                                  res = {1'b0, m};
        end else begin
            if (mag > {{(QW-DW){1'b0}}, NEG_MIN}) res = {1'b1, NEG_MIN};
            else                                  res = {1'b0, -m};
        end
        return res;
    endfunction

endpackage

// File: rtl/div16_seq_divu.sv
// Unsigned 24/8 restoring divider core: one quotient bit per step.
// The quotient shifts into the dividend register as dividend bits shift out.
module divu_core
    import fft_fix_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [QW-1:0] i_dvd,
    input  logic [CW-1:0] i_dvs,
    output logic          o_last,
    output logic [QW-1:0] o_quo_nxt
);

    logic [QW-1:0]   r_dvd;
    logic [RW-1:0]   r_rem;
    logic [CW-1:0]   r_dvs;
    logic [CNTW-1:0] r_cnt;

    logic [RW:0]     w_sh;
    logic            w_ge;
    logic [RW-1:0]   w_rem_nxt;

    always_comb begin
        w_sh      = {r_rem, r_dvd[QW-1]};
        w_ge      = (w_sh >= {2'b00, r_dvs});
        w_rem_nxt = w_ge ? RW'(w_sh - {2'b00, r_dvs}) : w_sh[RW-1:0];
        o_quo_nxt = {r_dvd[QW-2:0], w_ge};
        o_last    = (r_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dvd <= '0;
            r_rem <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_dvd <= i_dvd;
            r_rem <= '0;
            r_dvs <= i_dvs;
            r_cnt <= CNTW'(QW - 1);
        end else if (i_step) begin
            r_dvd <= o_quo_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - CNTW'(1);
        end
    end

endmodule

// File: rtl/div16_seq.sv
// Sequential signed divider q = (a * 2^FRAC) / b, inverse of the 17x8 fractional multiply.
// Sign handling, saturation and valid/ready handshakes around the unsigned core.
module div16_seq
    import fft_fix_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [CW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_q,
    output logic          out_sat,
    output logic          out_div0
);

    state_t        r_state;
    logic          r_sign;
    logic [DW-1:0] r_q;
    logic          r_sat;
    logic          r_div0;

    logic [DW-1:0] w_abs_a;
    logic [CW-1:0] w_abs_b;
    logic          w_b_zero;
    logic          w_load;
    logic          w_step;
    logic          w_last;
    logic [QW-1:0] w_dvd;
    logic [QW-1:0] w_quo_nxt;
    logic [DW:0]   w_res;

    // Magnitudes stay unsigned at full width: -65536 -> 65536, -128 -> 128.
    always_comb begin
        w_abs_a  = in_a[DW-1] ? -in_a : in_a;
        w_abs_b  = in_b[CW-1] ? -in_b : in_b;
        w_b_zero = (in_b == '0);
        w_load   = in_valid && (r_state == IDLE) && !w_b_zero;
        w_step   = (r_state == CALC);
        w_dvd    = {w_abs_a, {FRAC{1'b0}}};
        w_res    = sat_quot(r_sign, w_quo_nxt);
    end

    divu_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_dvd     (w_dvd),
        .i_dvs     (w_abs_b),
        .o_last    (w_last),
        .o_quo_nxt (w_quo_nxt)
    );

    // The result is formed from the core's final-step quotient on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sign  <= 1'b0;
            r_q     <= '0;
            r_sat   <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign <= in_a[DW-1] ^ in_b[CW-1];
                        if (w_b_zero) begin
                            r_state <= DONE;
                            r_q     <= in_a[DW-1] ? NEG_MIN : POS_MAX;
                            r_sat   <= 1'b1;
                            r_div0  <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (w_last) begin
                        r_state <= DONE;
                        r_q     <= w_res[DW-1:0];
                        r_sat   <= w_res[DW];
                        r_div0  <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_q     = r_q;
    assign out_sat   = r_sat;
    assign out_div0  = r_div0;

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: directed vectors, random operands against an
// arithmetic reference, backpressure, throughput and mid-operation reset.
module tb_div16_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [16:0] in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_ready, out_valid, out_sat, out_div0;
    logic [16:0] out_q;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    div16_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_sat   (out_sat),
        .out_div0  (out_div0)
    );

    int unsigned cyc = 0;
    int unsigned acc_cnt = 0;
    int unsigned acc_cyc = 0;
    int unsigned out_cnt = 0;
    logic [18:0] out_rec = '0;   // {div0, sat, q} of the last consumed result

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc;
        end
        if (rst_n && out_valid && out_ready) begin
            out_cnt <= out_cnt + 1;
            out_rec <= {out_div0, out_sat, out_q};
        end
    end

    // Reference: signed integer arithmetic, truncation toward zero, then clamp.
    function automatic logic [18:0] ref_div(input logic [16:0] a, input logic [7:0] b);
        longint sa, sb, qq;
        logic [63:0] qv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) return {2'b11, (sa < 0) ? 17'h10000 : 17'h0FFFF};
        qq = (sa * 128) / sb;
        if (qq > 65535)  return {2'b01, 17'h0FFFF};
        if (qq < -65536) return {2'b01, 17'h10000};
        qv = qq;
        return {2'b00, qv[16:0]};
    endfunction

    task automatic send(input logic [16:0] a, input logic [7:0] b);
        int unsigned start;
        bit got;
        start = acc_cnt;
        got = 0;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (acc_cnt != start) got = 1;
        end
        in_valid = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL accept_timeout got=none want=accept a=%h b=%h", a, b);
        end
    endtask

    task automatic recv(output logic [18:0] rec);
        int unsigned start;
        bit got;
        start = out_cnt;
        got = 0;
        out_ready = 1'b1;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (out_cnt != start) got = 1;
        end
        out_ready = 1'b0;
        rec = out_rec;
        total++;
        if (!got) begin
            bad++;
            rec = 'x;
            $display("FAIL result_timeout got=none want=out_valid");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if ({out_div0, out_sat, out_q} !== 19'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h/%b/%b want=00000/0/0", out_q, out_sat, out_div0);
        end
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [16:0] a;
        logic [7:0]  b;
        logic [16:0] q;
        logic        sat;
        logic        div0;
        logic [7:0]  lat;
    } vec_t;

    task automatic test_vectors();
        vec_t v [13] = '{
            '{17'h003E8, 8'h40, 17'h007D0, 1'b0, 1'b0, 8'd25},
            '{17'h1FC18, 8'h40, 17'h1F830, 1'b0, 1'b0, 8'd25},
            '{17'h1FFF9, 8'h03, 17'h1FED6, 1'b0, 1'b0, 8'd25},
            '{17'h003E8, 8'hFF, 17'h10000, 1'b1, 1'b0, 8'd25},
            '{17'h003E8, 8'h01, 17'h0FFFF, 1'b1, 1'b0, 8'd25},
            '{17'h00005, 8'h00, 17'h0FFFF, 1'b1, 1'b1, 8'd1},
            '{17'h10000, 8'h00, 17'h10000, 1'b1, 1'b1, 8'd1},
            '{17'h1FFFF, 8'h80, 17'h00001, 1'b0, 1'b0, 8'd25},
            '{17'h10000, 8'h80, 17'h0FFFF, 1'b1, 1'b0, 8'd25},
            '{17'h10001, 8'h80, 17'h0FFFF, 1'b0, 1'b0, 8'd25},
            '{17'h08000, 8'hC0, 17'h10000, 1'b0, 1'b0, 8'd25},
            '{17'h0FFFF, 8'h80, 17'h10001, 1'b0, 1'b0, 8'd25},
            '{17'h00000, 8'h85, 17'h00000, 1'b0, 1'b0, 8'd25}
        };
        logic [18:0] rec;
        int lat;
        foreach (v[i]) begin
            send(v[i].a, v[i].b);
            lat = 1;
            while (!out_valid && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            total++;
            if (lat != int'(v[i].lat)) begin
                bad++;
                $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, v[i].lat);
            end
            recv(rec);
            total++;
            if (rec !== {v[i].div0, v[i].sat, v[i].q}) begin
                bad++;
                $display("FAIL vec%0d_result got=%h/%b/%b want=%h/%b/%b", i,
                         rec[16:0], rec[17], rec[18], v[i].q, v[i].sat, v[i].div0);
            end
        end
    endtask

    task automatic test_random();
        logic [16:0] a;
        logic [7:0]  b;
        logic [18:0] rec, exp;
        for (int i = 0; i < 40; i++) begin
            a = 17'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1) ? 17'h10000 : 17'h0FFFF;
            exp = ref_div(a, b);
            send(a, b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            recv(rec);
            total++;
            if (rec !== exp) begin
                bad++;
                $display("FAIL rand%0d a=%h b=%h got=%h/%b/%b want=%h/%b/%b", i, a, b,
                         rec[16:0], rec[17], rec[18], exp[16:0], exp[17], exp[18]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] held;
        logic [18:0] rec;
        int n;
        send(17'h003E8, 8'h40);
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        held = out_q;
        total++;
        if (held !== 17'h007D0) begin bad++; $display("FAIL bp_value got=%h want=007d0", held); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (out_q !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got=q%h v%b r%b want=q%h v1 r0", i, out_q, out_valid, in_ready, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release got=r%b v%b want=r1 v0", in_ready, out_valid);
        end
        send(17'h1FFF9, 8'h03);
        recv(rec);
        total++;
        if (rec !== {2'b00, 17'h1FED6}) begin
            bad++;
            $display("FAIL bp_second got=%h/%b/%b want=1fed6/0/0", rec[16:0], rec[17], rec[18]);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned c1, c2;
        logic [18:0] rec;
        out_ready = 1'b1;
        send(17'h00123, 8'h11);
        c1 = acc_cyc;
        send(17'h1ABCD, 8'hE5);
        c2 = acc_cyc;
        total++;
        if (out_rec !== ref_div(17'h00123, 8'h11)) begin
            bad++;
            $display("FAIL b2b_first got=%h want=%h", out_rec, ref_div(17'h00123, 8'h11));
        end
        total++;
        if (c2 - c1 != 26) begin
            bad++;
            $display("FAIL b2b_period got=%0d want=26", c2 - c1);
        end
        recv(rec);
        total++;
        if (rec !== ref_div(17'h1ABCD, 8'hE5)) begin
            bad++;
            $display("FAIL b2b_second got=%h want=%h", rec, ref_div(17'h1ABCD, 8'hE5));
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] rec;
        int lat;
        send(17'h003E8, 8'h40);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_q !== 17'h0) begin
            bad++;
            $display("FAIL midrst_state got=v%b r%b q%h want=v0 r1 q00000", out_valid, in_ready, out_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(17'h00007, 8'h03);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != 25) begin bad++; $display("FAIL midrst_latency got=%0d want=25", lat); end
        recv(rec);
        total++;
        if (rec !== {2'b00, 17'h0012A}) begin
            bad++;
            $display("FAIL midrst_result got=%h/%b/%b want=0012a/0/0", rec[16:0], rec[17], rec[18]);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/div16_seq.md
Name: div16_seq

Overview:
- Sequential fixed-point divider; the inverse of the FFT datapath's 17-bit × 8-bit fractional multiply.
- Computes q = (a × 2^7) / b, where:
  - a is a 17-bit two's-complement data word.
  - b is an 8-bit two's-complement Q1.7 coefficient.
- Used by the normalisation/twiddle-calibration path to undo a coefficient scaling.
- Restoring radix-2 algorithm, one quotient bit per clock, with valid/ready handshakes on both sides.

Parameters:
- DW, 17, data/quotient width (two's complement).
- CW, 8, coefficient width (two's complement, Q1.7).
- FRAC, 7, fractional bits of the coefficient (pre-shift applied to the dividend).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands.
- in_a  input  DW  dividend, two's complement.
- in_b  input  CW  divisor, two's complement Q1.7.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_q  output  DW  quotient, two's complement.
- out_sat  output  1  quotient was clamped to the range limits.
- out_div0  output  1  divisor was zero.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE, in_ready=1, out_valid=0, out_q=0, out_sat=0, out_div0=0.
  - Overrides any operation in progress; the partial result is discarded.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid&in_ready at edge T. At T the block latches:
    - sign = a[16]^b[7].
    - |a| (17-bit unsigned; -65536 gives 65536).
    - |b| (8-bit unsigned; -128 gives 128).
  - If |b|==0: go to DONE.
  - Otherwise: load dividend = |a|<<7 (24 bits), clear the 9-bit remainder, counter=23, go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle: rem = {rem, dividend msb}; if rem>=|b|, subtract and shift in quotient bit 1, else shift in 0.
  - Runs exactly 24 cycles; counter counts 23..0; leaves to DONE when counter==0.
- DONE:
  - out_valid=1; out_q, out_sat and out_div0 stay stable until out_valid&out_ready.
  - Returns to IDLE on the edge where out_valid&out_ready.
  - No new operand is accepted in the same cycle; in_ready rises the cycle after.
- Latency: out_valid rises at edge T+25 for normal division and T+1 for divide-by-zero.
- Throughput: one result per 26 cycles when out_ready is held high.
- Result formation, registered on entry to DONE:
  - Quotient magnitude Q (24 bits) is truncated toward zero.
  - sign=0: Q>65535 gives out_q=17'h0FFFF and out_sat=1; otherwise out_q=Q.
  - sign=1: Q>65536 gives out_q=17'h10000 and out_sat=1; otherwise out_q=-Q mod 2^17.
  - Q==0 gives out_q=0 regardless of sign (no negative zero).
  - |b|==0: out_div0=1 and out_sat=1; out_q=17'h0FFFF if a[16]==0, else 17'h10000.
- Simultaneous events:
  - in_valid is ignored while not IDLE; the source must hold operands until in_ready.
  - out_ready is don't-care unless out_valid=1.
  - Reset has priority over every handshake.
- Arithmetic widths:
  - Remainder is 9 bits, because |b| can be 128.
  - No intermediate overflow is possible.

Decomposition:
- Shared package fft_fix_pkg holds:
  - Widths DW=17, CW=8, FRAC=7.
  - Saturation constants POS_MAX=17'h0FFFF and NEG_MIN=17'h10000.
  - State enum {IDLE, CALC, DONE}.
- Optional sub-module divu_core: the unsigned 24/8 iterative restoring core (load, step, count).
- The top level keeps the sign handling, saturation and handshakes.

Test Plan:
- a=17'h003E8 (1000), b=8'h40 (0.5) → out_q=17'h007D0 (2000), sat=0, div0=0; out_valid exactly 25 cycles after accept.
- a=17'h1FC18 (-1000), b=8'h40 → out_q=17'h1F830 (-2000). Then a=17'h1FFF9 (-7), b=8'h03 → out_q=17'h1FED6 (-298, truncated toward zero).
- a=17'h003E8, b=8'hFF (-1/128) → true result -128000 → out_q=17'h10000, sat=1. Also a=17'h003E8, b=8'h01 → out_q=17'h0FFFF, sat=1.
- a=17'h00005, b=8'h00 → out_q=17'h0FFFF, div0=1, sat=1, out_valid 1 cycle after accept. Also a=17'h10000, b=0 → out_q=17'h10000.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid; out_q stays stable and in_ready stays 0.
  - Then pulse out_ready; in_ready=1 on the next cycle.
  - A back-to-back second operand gives the correct result.
- Reset mid-operation:
  - Drop rst_n at cycle 12 of CALC → next edge state=IDLE, out_valid=0, in_ready=1.
  - The next operation a=7, b=3 → out_q=17'h0012A (298).
